// File: rtl/vr_pkg.sv
// Shared VR definitions for the PrepareOK quorum engine: FSM states,
// window slot layout, quorum size and ack popcount.
package vr_pkg;

    // Upper bound on replica group size; each slot stores this many ack bits.
    localparam int MAX_REPLICAS = 16;
    localparam int CNT_W        = 5;

    typedef enum logic [2:0] {
        ST_READY            = 3'd0,
        ST_CHECK            = 3'd1,
        ST_ADVANCE          = 3'd2,
        ST_SEND_COMMIT_META = 3'd3,
        ST_WRITE_STATE      = 3'd4
    } quorum_state_t;

    typedef struct packed {
        logic                    valid;
        logic [MAX_REPLICAS-1:0] ack;
    } prep_slot_t;

    function automatic int quorum_size(input int num_replicas);
        return num_replicas / 2 + 1;
    endfunction

    function automatic logic [CNT_W-1:0] ack_popcount(input logic [MAX_REPLICAS-1:0] ack);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < MAX_REPLICAS; i++) begin
            cnt = cnt + CNT_W'(ack[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/prep_ok_quorum_ctrl_if.sv
// Handshake/bus bundle between the VR pipeline and the PrepareOK quorum engine.
// The slave modport is the engine side.
interface prep_ok_quorum_ctrl_if #(
    parameter int NUM_REPLICAS = 3,
    parameter int OP_W         = 64
);
    localparam int REPL_W = (NUM_REPLICAS > 1) ? $clog2(NUM_REPLICAS) : 1;

    logic              op_issue_val;
    logic              op_issue_rdy;
    logic [OP_W-1:0]   op_issue_num;

    logic              manage_prepok_msg_val;
    logic              prepok_manage_msg_rdy;
    logic [31:0]       manage_prepok_view;
    logic [OP_W-1:0]   manage_prepok_op_num;
    logic [REPL_W-1:0] manage_prepok_replica;

    logic [31:0]       cur_view;

    logic              commit_to_udp_meta_val;
    logic              to_udp_commit_meta_rdy;
    logic [OP_W-1:0]   commit_num;
    logic              quorum_vr_state_wr_req;
    logic              window_full;
    logic              quorum_engine_rdy;

    modport master (
        output op_issue_val, op_issue_num,
        output manage_prepok_msg_val, manage_prepok_view,
        output manage_prepok_op_num, manage_prepok_replica,
        output cur_view, to_udp_commit_meta_rdy,
        input  op_issue_rdy, prepok_manage_msg_rdy,
        input  commit_to_udp_meta_val, commit_num,
        input  quorum_vr_state_wr_req, window_full, quorum_engine_rdy
    );

    modport slave (
        input  op_issue_val, op_issue_num,
        input  manage_prepok_msg_val, manage_prepok_view,
        input  manage_prepok_op_num, manage_prepok_replica,
        input  cur_view, to_udp_commit_meta_rdy,
        output op_issue_rdy, prepok_manage_msg_rdy,
        output commit_to_udp_meta_val, commit_num,
        output quorum_vr_state_wr_req, window_full, quorum_engine_rdy
    );

endinterface

// File: rtl/prep_ok_slot_table.sv
// Outstanding-op window: one slot per op (indexed by low op-number bits) holding
// a valid flag and the replica ack bitmap, with popcount on the read port.
module prep_ok_slot_table
    import vr_pkg::*;
#(
    parameter int LEADER_IDX  = 0,
    parameter int WINDOW_LOG2 = 3,
    parameter int REPL_W      = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   issue_en,
    input  logic [WINDOW_LOG2-1:0] issue_idx,
    input  logic                   ack_en,
    input  logic [WINDOW_LOG2-1:0] ack_idx,
    input  logic [REPL_W-1:0]      ack_replica,
    input  logic                   clear_en,
    input  logic [WINDOW_LOG2-1:0] clear_idx,
    input  logic [WINDOW_LOG2-1:0] rd_idx,
    output logic                   rd_valid,
    output logic [CNT_W-1:0]       rd_count
);
    localparam int WINDOW = 1 << WINDOW_LOG2;
    localparam logic [MAX_REPLICAS-1:0] LEADER_MASK = MAX_REPLICAS'(1) << LEADER_IDX;

    prep_slot_t [WINDOW-1:0]  slot_vec;
    logic [MAX_REPLICAS-1:0]  ack_mask;

    assign ack_mask = MAX_REPLICAS'(1) << ack_replica;

    generate
        for (genvar gi = 0; gi < WINDOW; gi++) begin : g_slot
            prep_slot_t slot_reg;

            // Issue, ack and clear come from mutually exclusive FSM states.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    slot_reg <= '0;
                end else if (issue_en && issue_idx == WINDOW_LOG2'(gi)) begin
                    slot_reg.valid <= 1'b1;
                    slot_reg.ack   <= LEADER_MASK;
                end else if (ack_en && ack_idx == WINDOW_LOG2'(gi)) begin
                    slot_reg.ack   <= slot_reg.ack | ack_mask;
                end else if (clear_en && clear_idx == WINDOW_LOG2'(gi)) begin
                    slot_reg.valid <= 1'b0;
                end
            end

            assign slot_vec[gi] = slot_reg;
        end
    endgenerate

    assign rd_valid = slot_vec[rd_idx].valid;
    assign rd_count = ack_popcount(slot_vec[rd_idx].ack);

endmodule

// File: rtl/prep_ok_quorum_ctrl.sv
// Leader-side PrepareOK quorum engine: tracks acks per outstanding op, advances
// commit_num in order once a quorum is reached, then emits one Commit and VR write.
module prep_ok_quorum_ctrl
    import vr_pkg::*;
#(
    parameter int NUM_REPLICAS = 3,
    parameter int LEADER_IDX   = 0,
    parameter int OP_W         = 64,
    parameter int WINDOW_LOG2  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    prep_ok_quorum_ctrl_if.slave  bus
);
    localparam int WINDOW = 1 << WINDOW_LOG2;
    localparam int REPL_W = (NUM_REPLICAS > 1) ? $clog2(NUM_REPLICAS) : 1;
    localparam logic [CNT_W-1:0] QUORUM = CNT_W'(quorum_size(NUM_REPLICAS));

    quorum_state_t     state_reg;
    logic [OP_W-1:0]   commit_num_reg;
    logic [OP_W-1:0]   last_issued_reg;
    logic [31:0]       msg_view_reg;
    logic [OP_W-1:0]   msg_op_reg;
    logic [REPL_W-1:0] msg_replica_reg;
    logic              advanced_reg;
    logic              meta_val_reg;
    logic              wr_req_reg;
    logic              engine_rdy_reg;

    logic [OP_W-1:0]   next_commit;
    logic              issue_fire;
    logic              msg_fire;
    logic              msg_drop;
    logic              commit_now;
    logic              rd_valid;
    logic [CNT_W-1:0]  rd_count;

    assign next_commit = commit_num_reg + OP_W'(1);

    assign bus.window_full            = (last_issued_reg - commit_num_reg) == OP_W'(WINDOW);
    assign bus.op_issue_rdy           = engine_rdy_reg & ~bus.window_full;
    // A new Prepare takes priority over a PrepareOK arriving in the same cycle.
    assign bus.prepok_manage_msg_rdy  = engine_rdy_reg & ~bus.op_issue_val;
    assign bus.commit_to_udp_meta_val = meta_val_reg;
    assign bus.quorum_vr_state_wr_req = wr_req_reg;
    assign bus.quorum_engine_rdy      = engine_rdy_reg;
    assign bus.commit_num             = commit_num_reg;

    assign issue_fire = bus.op_issue_val & bus.op_issue_rdy;
    assign msg_fire   = bus.manage_prepok_msg_val & bus.prepok_manage_msg_rdy;

    assign msg_drop = (msg_view_reg != bus.cur_view)
                    | (msg_op_reg <= commit_num_reg)
                    | (msg_op_reg > last_issued_reg)
                    | (32'(msg_replica_reg) >= $unsigned(NUM_REPLICAS));

    assign commit_now = (state_reg == ST_ADVANCE) & rd_valid & (rd_count >= QUORUM);

    prep_ok_slot_table #(
        .LEADER_IDX  (LEADER_IDX),
        .WINDOW_LOG2 (WINDOW_LOG2),
        .REPL_W      (REPL_W)
    ) u_slot_table (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_en    (issue_fire),
        .issue_idx   (bus.op_issue_num[WINDOW_LOG2-1:0]),
        .ack_en      ((state_reg == ST_CHECK) & ~msg_drop),
        .ack_idx     (msg_op_reg[WINDOW_LOG2-1:0]),
        .ack_replica (msg_replica_reg),
        .clear_en    (commit_now),
        .clear_idx   (next_commit[WINDOW_LOG2-1:0]),
        .rd_idx      (next_commit[WINDOW_LOG2-1:0]),
        .rd_valid    (rd_valid),
        .rd_count    (rd_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_READY;
            commit_num_reg  <= '0;
            last_issued_reg <= '0;
            msg_view_reg    <= '0;
            msg_op_reg      <= '0;
            msg_replica_reg <= '0;
            advanced_reg    <= 1'b0;
            meta_val_reg    <= 1'b0;
            wr_req_reg      <= 1'b0;
            engine_rdy_reg  <= 1'b1;
        end else begin
            case (state_reg)
                ST_READY: begin
                    if (issue_fire) begin
                        last_issued_reg <= bus.op_issue_num;
                    end
                    if (msg_fire) begin
                        msg_view_reg    <= bus.manage_prepok_view;
                        msg_op_reg      <= bus.manage_prepok_op_num;
                        msg_replica_reg <= bus.manage_prepok_replica;
                        engine_rdy_reg  <= 1'b0;
                        state_reg       <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    advanced_reg <= 1'b0;
                    if (msg_drop) begin
                        engine_rdy_reg <= 1'b1;
                        state_reg      <= ST_READY;
                    end else begin
                        state_reg      <= ST_ADVANCE;
                    end
                end
                ST_ADVANCE: begin
                    // Commit at most one op per cycle, strictly in op-number order.
                    if (commit_now) begin
                        commit_num_reg <= next_commit;
                        advanced_reg   <= 1'b1;
                    end else if (advanced_reg) begin
                        meta_val_reg   <= 1'b1;
                        state_reg      <= ST_SEND_COMMIT_META;
                    end else begin
                        engine_rdy_reg <= 1'b1;
                        state_reg      <= ST_READY;
                    end
                end
                ST_SEND_COMMIT_META: begin
                    if (bus.to_udp_commit_meta_rdy) begin
                        meta_val_reg <= 1'b0;
                        wr_req_reg   <= 1'b1;
                        state_reg    <= ST_WRITE_STATE;
                    end
                end
                ST_WRITE_STATE: begin
                    wr_req_reg     <= 1'b0;
                    engine_rdy_reg <= 1'b1;
                    state_reg      <= ST_READY;
                end
                default: begin
                    state_reg      <= quorum_state_t'('x);
                    meta_val_reg   <= 1'bx;
                    wr_req_reg     <= 1'bx;
                    engine_rdy_reg <= 1'bx;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prep_ok_quorum_ctrl.sv
// Directed bench for prep_ok_quorum_ctrl: quorum commit, out-of-order acks,
// dropped messages, window full, issue/ack collision and reset mid-commit.
module tb_prep_ok_quorum_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    prep_ok_quorum_ctrl_if #(.NUM_REPLICAS(3), .OP_W(64)) bus();

    prep_ok_quorum_ctrl #(
        .NUM_REPLICAS (3),
        .LEADER_IDX   (0),
        .OP_W         (64),
        .WINDOW_LOG2  (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fails  = 0;
    int wr_cnt   = 0;
    int wr_base  = 0;

    always @(posedge clk) begin
        if (bus.quorum_vr_state_wr_req === 1'b1) wr_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue_op(input logic [63:0] n);
        bus.op_issue_val = 1'b1;
        bus.op_issue_num = n;
        tick();
        bus.op_issue_val = 1'b0;
        $display("issue op %0d", n);
    endtask

    // Presents one PrepareOK and takes the handshake edge; returns at edge+1.
    task automatic send_ok(input logic [31:0] v, input logic [63:0] op, input logic [1:0] rep);
        bus.manage_prepok_msg_val = 1'b1;
        bus.manage_prepok_view    = v;
        bus.manage_prepok_op_num  = op;
        bus.manage_prepok_replica = rep;
        #1;
        check("msg_rdy", bus.prepok_manage_msg_rdy, 1'b1);
        @(posedge clk);
        #1;
        bus.manage_prepok_msg_val = 1'b0;
        $display("prepok view=%0d op=%0d replica=%0d", v, op, rep);
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 30 && bus.quorum_engine_rdy !== 1'b1; i++) tick();
        check(tag, bus.quorum_engine_rdy, 1'b1);
    endtask

    task automatic send_drop(input logic [31:0] v, input logic [63:0] op, input logic [1:0] rep);
        send_ok(v, op, rep);
        check("drop_in_check", bus.quorum_engine_rdy, 1'b0);
        tick();
        check("drop_back_ready", bus.quorum_engine_rdy, 1'b1);
        check("drop_commit", bus.commit_num, 64'd4);
    endtask

    initial begin
        bus.op_issue_val           = 1'b0;
        bus.op_issue_num           = '0;
        bus.manage_prepok_msg_val  = 1'b0;
        bus.manage_prepok_view     = '0;
        bus.manage_prepok_op_num   = '0;
        bus.manage_prepok_replica  = '0;
        bus.cur_view               = 32'd5;
        bus.to_udp_commit_meta_rdy = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_commit_num", bus.commit_num, 64'd0);
        check("rst_meta_val", bus.commit_to_udp_meta_val, 1'b0);
        check("rst_wr_req", bus.quorum_vr_state_wr_req, 1'b0);
        check("rst_window_full", bus.window_full, 1'b0);
        check("rst_engine_rdy", bus.quorum_engine_rdy, 1'b1);
        check("rst_issue_rdy", bus.op_issue_rdy, 1'b1);
        check("rst_msg_rdy", bus.prepok_manage_msg_rdy, 1'b1);
        rst_n = 1'b1;
        tick();

        // Single op commit with 3-cycle meta latency and one wr_req pulse
        wr_base = wr_cnt;
        issue_op(64'd1);
        send_ok(32'd5, 64'd1, 2'd1);
        check("t1_c0_meta", bus.commit_to_udp_meta_val, 1'b0);
        check("t1_c0_busy", bus.quorum_engine_rdy, 1'b0);
        tick();
        check("t1_c1_meta", bus.commit_to_udp_meta_val, 1'b0);
        tick();
        check("t1_c2_commit", bus.commit_num, 64'd1);
        check("t1_c2_meta", bus.commit_to_udp_meta_val, 1'b0);
        tick();
        check("t1_c3_meta", bus.commit_to_udp_meta_val, 1'b1);
        tick();
        check("t1_c4_wr_req", bus.quorum_vr_state_wr_req, 1'b1);
        check("t1_c4_meta", bus.commit_to_udp_meta_val, 1'b0);
        tick();
        check("t1_c5_wr_req", bus.quorum_vr_state_wr_req, 1'b0);
        check("t1_c5_ready", bus.quorum_engine_rdy, 1'b1);
        check("t1_wr_pulses", 64'(wr_cnt - wr_base), 64'd1);

        // Out-of-order acks: ops 2..4 commit only once op 2 is acked
        wr_base = wr_cnt;
        issue_op(64'd2);
        issue_op(64'd3);
        issue_op(64'd4);
        send_ok(32'd5, 64'd4, 2'd2);
        wait_ready("t2_ack4_ready");
        check("t2_ack4_commit", bus.commit_num, 64'd1);
        send_ok(32'd5, 64'd3, 2'd2);
        wait_ready("t2_ack3_ready");
        check("t2_ack3_commit", bus.commit_num, 64'd1);
        send_ok(32'd5, 64'd2, 2'd2);
        tick();
        check("t2_adv0_commit", bus.commit_num, 64'd1);
        tick();
        check("t2_adv1_commit", bus.commit_num, 64'd2);
        tick();
        check("t2_adv2_commit", bus.commit_num, 64'd3);
        tick();
        check("t2_adv3_commit", bus.commit_num, 64'd4);
        tick();
        check("t2_meta", bus.commit_to_udp_meta_val, 1'b1);
        wait_ready("t2_done_ready");
        check("t2_wr_pulses", 64'(wr_cnt - wr_base), 64'd1);

        // Dropped messages leave no trace in the ack bitmap
        issue_op(64'd5);
        send_drop(32'd6, 64'd5, 2'd1);
        send_drop(32'd5, 64'd0, 2'd1);
        send_drop(32'd5, 64'd9, 2'd1);
        send_drop(32'd5, 64'd5, 2'd3);
        send_ok(32'd5, 64'd5, 2'd0);
        wait_ready("t3_leader_ready");
        check("t3_leader_no_commit", bus.commit_num, 64'd4);
        send_ok(32'd5, 64'd5, 2'd1);
        wait_ready("t3_ack_ready");
        check("t3_commit", bus.commit_num, 64'd5);

        // Window full after 8 outstanding ops
        for (int n = 6; n <= 12; n++) issue_op(64'(n));
        check("t4_not_full", bus.window_full, 1'b0);
        issue_op(64'd13);
        check("t4_full", bus.window_full, 1'b1);
        bus.op_issue_val = 1'b1;
        bus.op_issue_num = 64'd14;
        #1;
        check("t4_issue_rdy_low", bus.op_issue_rdy, 1'b0);
        tick();
        bus.op_issue_val = 1'b0;
        check("t4_still_full", bus.window_full, 1'b1);
        send_ok(32'd5, 64'd6, 2'd2);
        wait_ready("t4_ack_ready");
        check("t4_commit", bus.commit_num, 64'd6);
        check("t4_full_cleared", bus.window_full, 1'b0);
        check("t4_issue_rdy_back", bus.op_issue_rdy, 1'b1);

        // Simultaneous issue and PrepareOK: issue first, message next cycle
        bus.op_issue_val          = 1'b1;
        bus.op_issue_num          = 64'd14;
        bus.manage_prepok_msg_val = 1'b1;
        bus.manage_prepok_view    = 32'd5;
        bus.manage_prepok_op_num  = 64'd7;
        bus.manage_prepok_replica = 2'd1;
        #1;
        check("t5_msg_rdy_low", bus.prepok_manage_msg_rdy, 1'b0);
        check("t5_issue_rdy", bus.op_issue_rdy, 1'b1);
        tick();
        bus.op_issue_val = 1'b0;
        $display("issue op 14 with colliding prepok op 7");
        check("t5_still_ready", bus.quorum_engine_rdy, 1'b1);
        #1;
        check("t5_msg_rdy_high", bus.prepok_manage_msg_rdy, 1'b1);
        tick();
        bus.manage_prepok_msg_val = 1'b0;
        check("t5_msg_taken", bus.quorum_engine_rdy, 1'b0);
        wait_ready("t5_ready");
        check("t5_commit", bus.commit_num, 64'd7);
        check("t5_window", bus.window_full, 1'b0);

        // Reset while a Commit is held waiting for the UDP side
        bus.to_udp_commit_meta_rdy = 1'b0;
        send_ok(32'd5, 64'd8, 2'd1);
        for (int i = 0; i < 10 && bus.commit_to_udp_meta_val !== 1'b1; i++) tick();
        check("t6_meta_up", bus.commit_to_udp_meta_val, 1'b1);
        check("t6_commit", bus.commit_num, 64'd8);
        tick();
        tick();
        check("t6_meta_held", bus.commit_to_udp_meta_val, 1'b1);
        wr_base = wr_cnt;
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset during commit send");
        check("t6_rst_meta", bus.commit_to_udp_meta_val, 1'b0);
        check("t6_rst_commit", bus.commit_num, 64'd0);
        check("t6_rst_ready", bus.quorum_engine_rdy, 1'b1);
        check("t6_rst_window", bus.window_full, 1'b0);
        bus.to_udp_commit_meta_rdy = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("t6_no_wr_req", 64'(wr_cnt - wr_base), 64'd0);
        check("t6_meta_low", bus.commit_to_udp_meta_val, 1'b0);

        // Engine works normally after the reset
        issue_op(64'd1);
        send_ok(32'd5, 64'd1, 2'd2);
        wait_ready("t7_ready");
        check("t7_commit", bus.commit_num, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/prep_ok_quorum_ctrl.md
PREP_OK_QUORUM_CTRL -- requirements
Module: prep_ok_quorum_ctrl

Interface
REQ-001 Parameter NUM_REPLICAS, default 3, replica group size (2f+1).
REQ-002 Parameter LEADER_IDX, default 0, this node's replica index.
REQ-003 Parameter OP_W, default 64, op-number width.
REQ-004 Parameter WINDOW_LOG2, default 3, log2 of outstanding-op window (WINDOW=8).
REQ-005 clk  in  1  sole clock; one clock, reset asynchronous active-low.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 op_issue_val / op_issue_rdy  in / out  1 / 1  leader issued new Prepare.
REQ-008 op_issue_num  in  OP_W  op number of issued Prepare.
REQ-009 manage_prepok_msg_val / prepok_manage_msg_rdy  in / out  1 / 1  PrepareOK metadata handshake.
REQ-010 manage_prepok_view  in  32  view in PrepareOK.
REQ-011 manage_prepok_op_num  in  OP_W  op acknowledged.
REQ-012 manage_prepok_replica  in  $clog2(NUM_REPLICAS)  sender index.
REQ-013 cur_view  in  32  current view from VR state.
REQ-014 commit_to_udp_meta_val / to_udp_commit_meta_rdy  out / in  1 / 1  Commit message metadata handshake.
REQ-015 commit_num  out  OP_W  committed op number (register).
REQ-016 quorum_vr_state_wr_req  out  1  one-cycle pulse writing commit_num to VR state.
REQ-017 window_full  out  1  (last_issued - commit_num) == WINDOW.
REQ-018 quorum_engine_rdy  out  1  high only in READY.

Function
REQ-019 Storage: WINDOW slots indexed by op_num[WINDOW_LOG2-1:0], each = valid bit + NUM_REPLICAS-bit ack bitmap; registers last_issued, commit_num; latched PrepareOK fields.
REQ-020 QUORUM = NUM_REPLICAS/2 + 1 (2 for 3 replicas); leader counts toward quorum.
REQ-021 States: READY, CHECK, ADVANCE, SEND_COMMIT_META, WRITE_STATE.
REQ-022 READY: op_issue_rdy = ~window_full; on op_issue handshake: slot valid=1, bitmap = only LEADER_IDX bit, last_issued = op_issue_num; stay READY.
REQ-023 READY: prepok_manage_msg_rdy = ~op_issue_val (issue wins simultaneous arrival); on handshake latch fields -> CHECK.
REQ-024 CHECK drops message (-> READY, no state change) if view != cur_view, op_num <= commit_num, op_num > last_issued, or replica >= NUM_REPLICAS.
REQ-025 CHECK otherwise sets bitmap bit for replica (duplicates idempotent) -> ADVANCE.
REQ-026 ADVANCE: if slot(commit_num+1) valid and popcount >= QUORUM: clear valid, commit_num += 1, stay; one op per cycle.
REQ-027 ADVANCE otherwise: -> SEND_COMMIT_META if commit_num advanced since CHECK, else -> READY.
REQ-028 SEND_COMMIT_META: commit_to_udp_meta_val=1 until to_udp_commit_meta_rdy, then -> WRITE_STATE.
REQ-029 WRITE_STATE: quorum_vr_state_wr_req=1 for exactly one cycle -> READY.
REQ-030 Latency: accepted PrepareOK completing quorum of next op -> meta_val asserted 3 cycles after handshake.
REQ-031 Op-number compares unsigned, full OP_W; no wrap handling required.
REQ-032 Undefined state: outputs X, next state X.

Reset
REQ-033 On rst_n low: state READY, commit_num=0, last_issued=0, all slots invalid, bitmaps 0.
REQ-034 Reset outputs: rdys per READY rules, commit_to_udp_meta_val=0, quorum_vr_state_wr_req=0, window_full=0, quorum_engine_rdy=1.
REQ-035 Reset mid-operation discards in-flight message and pending commit; no wr_req pulse.

Structure
REQ-036 State enum and QUORUM function live in shared VR package (vr_pkg); slot struct too.
REQ-037 Single module; optional sub-module prep_ok_slot_table holding slots and popcount.

Verification
REQ-038 Issue op 1, PrepareOK(view=cur, op 1, replica 1) -> commit_num 1, meta_val 3 cycles later, one wr_req pulse.
REQ-039 Issue ops 1-3; ACKs op 3 then op 2 then op 1 (replica 2) -> no commit until op 1 ACK, then commit_num 1->3 in 3 consecutive ADVANCE cycles, single Commit.
REQ-040 PrepareOK view=cur_view+1, op 0, op 9 > last_issued, replica 3 -> each consumed, no state change.
REQ-041 Issue ops 1-8 -> window_full=1, op_issue_rdy=0; commit op 1 -> window_full=0.
REQ-042 op_issue_val and msg_val same cycle -> issue accepted, msg_rdy=0, message taken next cycle.
REQ-043 rst_n low during SEND_COMMIT_META with rdy=0 -> meta_val drops immediately, commit_num=0, no wr_req.
